inst_fetch: RTL and testbench

- Initiator side of the instruction-memory read interface.
- Holds the PC and drives a word-aligned byte address each cycle.
- Captures the combinational 32-bit instruction returned by the memory and hands it to decode through a valid/ready interface.
- Buffers fetched words in a 2-entry prefetch FIFO, takes branch redirects, and stops fetching cleanly at the end of instruction memory.

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/inst_fetch.sv | 101 ++++++++++
 tb/tb_inst_fetch.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch unit.
package fetch_pkg;

  localparam int FETCH_ADDR_W     = 6;
  localparam int FETCH_INSTR_W    = 32;
  localparam int FETCH_FIFO_DEPTH = 2;
  localparam int PC_STEP          = 4;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    END   = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small prefetch FIFO of {pc, instr} entries; flush dominates push.
module fetch_fifo
  import fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t push_entry,
  output fetch_entry_t head,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(FETCH_FIFO_DEPTH);
  localparam int CNT_W = $clog2(FETCH_FIFO_DEPTH + 1);

  fetch_entry_t     mem [FETCH_FIFO_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(FETCH_FIFO_DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A pop frees a slot in the same cycle, so a full FIFO can still accept.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_entry;
  end

  assign head = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, memory address, prefetch FIFO, redirects, end-of-memory stop.
// Optional perf counters enabled with `define INST_FETCH_PERF_EN.
module inst_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W    = FETCH_ADDR_W,
  parameter int INSTR_W   = FETCH_INSTR_W,
  parameter int LAST_WORD = 60,
  parameter int RESET_PC  = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  input  logic               redir_valid,
  input  logic [ADDR_W-1:0]  redir_target,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               fetch_end
`ifdef INST_FETCH_PERF_EN
  ,
  output logic [15:0]        perf_fetched,
  output logic [15:0]        perf_stall
`endif
);

  // One extra PC bit so stepping past the last word never wraps to address 0.
  localparam int              PC_W     = ADDR_W + 1;
  localparam logic [PC_W-1:0] LAST_PC  = PC_W'(LAST_WORD);
  localparam logic [PC_W-1:0] START_PC = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] STEP     = PC_W'(PC_STEP);

  fetch_state_t    state;
  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] redir_pc;
  logic            pop;
  logic            fetch_go;
  logic            push_ok;
  logic            full;
  logic            empty;
  fetch_entry_t    wr_entry;
  fetch_entry_t    head;

  assign pc_inc   = pc + STEP;
  assign redir_pc = {1'b0, redir_target} & ~PC_W'(3);
  assign pop      = out_valid && out_ready;
  assign fetch_go = (state == FETCH) && (!full || pop);
  assign push_ok  = fetch_go && !redir_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc    <= START_PC;
      state <= FETCH;
    end else if (redir_valid) begin
      pc    <= redir_pc;
      state <= (redir_pc > LAST_PC) ? END : FETCH;
    end else if (push_ok) begin
      pc <= pc_inc;
      if (pc_inc > LAST_PC) state <= END;
    end
  end

  // Once past the end the address parks on the last word instead of wrapping.
  assign imem_addr = (pc > LAST_PC) ? LAST_PC[ADDR_W-1:0] : pc[ADDR_W-1:0];
  assign wr_entry  = {imem_addr, imem_instr};

  fetch_fifo u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (fetch_go),
    .pop        (pop),
    .flush      (redir_valid),
    .push_entry (wr_entry),
    .head       (head),
    .full       (full),
    .empty      (empty)
  );

  assign out_valid = !empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign fetch_end = (state == END) && empty;

`ifdef INST_FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched <= '0;
      perf_stall   <= '0;
    end else begin
      if (push_ok && perf_fetched != 16'hFFFF)
        perf_fetched <= perf_fetched + 16'd1;
      if (out_valid && !out_ready && perf_stall != 16'hFFFF)
        perf_stall <= perf_stall + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Directed self-checking bench for inst_fetch with a combinational 16-word memory.
module tb_inst_fetch;
  import fetch_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [5:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        redir_valid;
  logic [5:0]  redir_target;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [5:0]  out_pc;
  logic        fetch_end;
`ifdef INST_FETCH_PERF_EN
  logic [15:0] perf_fetched;
  logic [15:0] perf_stall;
`endif

  logic [31:0] mem [16];
  int          check_count;
  int          pass_count;

  inst_fetch dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_addr    (imem_addr),
    .imem_instr   (imem_instr),
    .redir_valid  (redir_valid),
    .redir_target (redir_target),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_instr    (out_instr),
    .out_pc       (out_pc),
    .fetch_end    (fetch_end)
`ifdef INST_FETCH_PERF_EN
    ,
    .perf_fetched (perf_fetched),
    .perf_stall   (perf_stall)
`endif
  );

  assign imem_instr = mem[imem_addr[5:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Holds reset for two cycles and releases it on a falling edge.
  task automatic apply_reset(input logic ready);
    out_ready    = ready;
    redir_valid  = 1'b0;
    redir_target = '0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    out_ready = 1'b1; redir_valid = 1'b0; redir_target = '0; rst_n = 1'b0;
    @(negedge clk);
    check_count++; if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid got %b want 0", out_valid); else pass_count++;
    check_count++; if (out_instr !== 32'h0) $display("[TB] FAIL reset_instr got %h want 0", out_instr); else pass_count++;
    check_count++; if (out_pc !== 6'h0) $display("[TB] FAIL reset_pc got %h want 0", out_pc); else pass_count++;
    check_count++; if (fetch_end !== 1'b0) $display("[TB] FAIL reset_end got %b want 0", fetch_end); else pass_count++;
    check_count++; if (imem_addr !== 6'h0) $display("[TB] FAIL reset_addr got %h want 0", imem_addr); else pass_count++;
  endtask

  task automatic test_stream;
    apply_reset(1'b1);
    check_count++; if (imem_addr !== 6'h00) $display("[TB] FAIL stream_addr0 got %h want 00", imem_addr); else pass_count++;
    @(negedge clk);
    check_count++; if (out_valid !== 1'b1 || out_pc !== 6'h00 || out_instr !== 32'h99368F7E)
      $display("[TB] FAIL stream_head0 got v=%b pc=%h i=%h want v=1 pc=00 i=99368f7e", out_valid, out_pc, out_instr); else pass_count++;
    check_count++; if (imem_addr !== 6'h04) $display("[TB] FAIL stream_addr1 got %h want 04", imem_addr); else pass_count++;
    @(negedge clk);
    check_count++; if (out_pc !== 6'h04 || out_instr !== 32'hD9F6EF7F)
      $display("[TB] FAIL stream_head1 got pc=%h i=%h want pc=04 i=d9f6ef7f", out_pc, out_instr); else pass_count++;
    check_count++; if (imem_addr !== 6'h08) $display("[TB] FAIL stream_addr2 got %h want 08", imem_addr); else pass_count++;
    @(negedge clk);
    check_count++; if (out_pc !== 6'h08 || out_instr !== 32'h0)
      $display("[TB] FAIL stream_head2 got pc=%h i=%h want pc=08 i=0", out_pc, out_instr); else pass_count++;
  endtask

  task automatic test_stall;
    apply_reset(1'b0);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      check_count++; if (out_valid !== 1'b1 || out_pc !== 6'h00 || out_instr !== 32'h99368F7E)
        $display("[TB] FAIL stall_hold%0d got v=%b pc=%h i=%h want v=1 pc=00 i=99368f7e", i, out_valid, out_pc, out_instr); else pass_count++;
      if (i >= 2) begin
        check_count++; if (imem_addr !== 6'h08) $display("[TB] FAIL stall_addr%0d got %h want 08", i, imem_addr); else pass_count++;
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_count++; if (out_pc !== 6'h04 || out_instr !== 32'hD9F6EF7F)
      $display("[TB] FAIL stall_resume1 got pc=%h i=%h want pc=04 i=d9f6ef7f", out_pc, out_instr); else pass_count++;
    @(negedge clk);
    check_count++; if (out_pc !== 6'h08 || imem_addr !== 6'h10)
      $display("[TB] FAIL stall_resume2 got pc=%h addr=%h want pc=08 addr=10", out_pc, imem_addr); else pass_count++;
  endtask

  task automatic test_end;
    logic [5:0] exp_pc;
    logic [5:0] last_pc;
    logic       seen;
    logic       done;
    apply_reset(1'b1);
    exp_pc = '0; last_pc = '0; seen = 1'b0; done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk);
      if (out_valid) begin
        check_count++; if (out_pc !== exp_pc) $display("[TB] FAIL end_seq got %h want %h", out_pc, exp_pc); else pass_count++;
        last_pc = out_pc;
        exp_pc  = exp_pc + 6'd4;
        seen    = 1'b1;
      end else if (seen) begin
        done = 1'b1;
      end
    end
    check_count++; if (done !== 1'b1) $display("[TB] FAIL end_timeout got %b want 1", done); else pass_count++;
    check_count++; if (last_pc !== 6'd60) $display("[TB] FAIL end_last_pc got %0d want 60", last_pc); else pass_count++;
    check_count++; if (fetch_end !== 1'b1) $display("[TB] FAIL end_flag got %b want 1", fetch_end); else pass_count++;
    repeat (3) @(negedge clk);
    check_count++; if (imem_addr !== 6'd60 || out_valid !== 1'b0 || fetch_end !== 1'b1)
      $display("[TB] FAIL end_park got addr=%0d v=%b e=%b want addr=60 v=0 e=1", imem_addr, out_valid, fetch_end); else pass_count++;
  endtask

  // Runs straight after test_end while the unit sits in END.
  task automatic test_redirect_from_end;
    redir_valid = 1'b1; redir_target = 6'h04;
    @(negedge clk);
    redir_valid = 1'b0;
    check_count++; if (out_valid !== 1'b0 || fetch_end !== 1'b0 || imem_addr !== 6'h04)
      $display("[TB] FAIL endredir_next got v=%b e=%b addr=%h want v=0 e=0 addr=04", out_valid, fetch_end, imem_addr); else pass_count++;
    @(negedge clk);
    check_count++; if (out_valid !== 1'b1 || out_pc !== 6'h04 || out_instr !== 32'hD9F6EF7F || fetch_end !== 1'b0)
      $display("[TB] FAIL endredir_head got v=%b pc=%h i=%h e=%b want v=1 pc=04 i=d9f6ef7f e=0",
               out_valid, out_pc, out_instr, fetch_end); else pass_count++;
  endtask

  task automatic test_redirect_flush;
    apply_reset(1'b0);
    repeat (2) @(negedge clk);
    redir_valid = 1'b1; redir_target = 6'h1A;
    @(negedge clk);
    redir_valid = 1'b0; out_ready = 1'b1;
    check_count++; if (out_valid !== 1'b0 || imem_addr !== 6'h18)
      $display("[TB] FAIL flush_next got v=%b addr=%h want v=0 addr=18", out_valid, imem_addr); else pass_count++;
    @(negedge clk);
    check_count++; if (out_valid !== 1'b1 || out_pc !== 6'h18)
      $display("[TB] FAIL flush_head got v=%b pc=%h want v=1 pc=18", out_valid, out_pc); else pass_count++;
  endtask

  task automatic test_back_to_back;
    redir_valid = 1'b1; redir_target = 6'h20;
    @(negedge clk);
    check_count++; if (imem_addr !== 6'h20) $display("[TB] FAIL b2b_first got %h want 20", imem_addr); else pass_count++;
    redir_target = 6'h08;
    @(negedge clk);
    redir_valid = 1'b0;
    check_count++; if (imem_addr !== 6'h08 || out_valid !== 1'b0)
      $display("[TB] FAIL b2b_second got addr=%h v=%b want addr=08 v=0", imem_addr, out_valid); else pass_count++;
    @(negedge clk);
    check_count++; if (out_valid !== 1'b1 || out_pc !== 6'h08)
      $display("[TB] FAIL b2b_head got v=%b pc=%h want v=1 pc=08", out_valid, out_pc); else pass_count++;
  endtask

  task automatic test_async_reset;
    @(negedge clk);
    check_count++; if (out_valid !== 1'b1) $display("[TB] FAIL areset_pre got %b want 1", out_valid); else pass_count++;
    #2 rst_n = 1'b0;
    #1;
    check_count++; if (out_valid !== 1'b0 || out_pc !== 6'h0 || out_instr !== 32'h0 || imem_addr !== 6'h0 || fetch_end !== 1'b0)
      $display("[TB] FAIL areset_clear got v=%b pc=%h i=%h addr=%h e=%b want all 0",
               out_valid, out_pc, out_instr, imem_addr, fetch_end); else pass_count++;
  endtask

`ifdef INST_FETCH_PERF_EN
  task automatic test_perf;
    apply_reset(1'b0);
    repeat (11) @(negedge clk);
    check_count++; if (perf_stall !== 16'd10) $display("[TB] FAIL perf_stall got %0d want 10", perf_stall); else pass_count++;
    check_count++; if (perf_fetched !== 16'd2) $display("[TB] FAIL perf_fetched got %0d want 2", perf_fetched); else pass_count++;
    #2 rst_n = 1'b0;
    #1;
    check_count++; if (perf_stall !== 16'd0 || perf_fetched !== 16'd0 || out_valid !== 1'b0)
      $display("[TB] FAIL perf_reset got s=%0d f=%0d v=%b want 0 0 0", perf_stall, perf_fetched, out_valid); else pass_count++;
  endtask
`endif

  initial begin
    check_count = 0;
    pass_count  = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h99368F7E;
    mem[1] = 32'hD9F6EF7F;
    test_reset;
    test_stream;
    test_stall;
    test_end;
    test_redirect_from_end;
    test_redirect_flush;
    test_back_to_back;
    test_async_reset;
`ifdef INST_FETCH_PERF_EN
    test_perf;
`endif
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
